io_sevenseg_scan: RTL and testbench



---
 rtl/io_sevenseg_scan.sv | 102 ++++++++++
 tb/tb_io_sevenseg_scan.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/io_sevenseg_scan.sv
// Six-digit multiplexed common-anode seven-segment driver for the MEM-stage output ports.
// Optional decimal display mode is enabled by defining IO_SCAN_DEC_EN (hex mode otherwise).
module io_sevenseg_scan #(
  parameter int DIV = 50000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] real_out_port0,
  input  logic [31:0] real_out_port1,
  input  logic [31:0] real_out_port2,
  output logic [5:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        frame_tick
);

  localparam logic [15:0] PRE_MAX = 16'(DIV - 1);

  logic [15:0] pre;
  logic [2:0]  dig;
  logic [7:0]  snap0, snap1, snap2;
  logic        tick;
  logic        wrap;
  logic [7:0]  byte_sel;
  logic [6:0]  seg_next;
  logic        unused_bits;

  assign unused_bits = ^{real_out_port0[31:8], real_out_port1[31:8], real_out_port2[31:8]};

  assign tick = (pre == PRE_MAX);
  assign wrap = tick && (dig == 3'd5);

  function automatic logic [6:0] hex_pattern(input logic [3:0] nib);
    case (nib)
      4'h0: hex_pattern = 7'h40;
      4'h1: hex_pattern = 7'h79;
      4'h2: hex_pattern = 7'h24;
      4'h3: hex_pattern = 7'h30;
      4'h4: hex_pattern = 7'h19;
      4'h5: hex_pattern = 7'h12;
      4'h6: hex_pattern = 7'h02;
      4'h7: hex_pattern = 7'h78;
      4'h8: hex_pattern = 7'h00;
      4'h9: hex_pattern = 7'h10;
      4'hA: hex_pattern = 7'h08;
      4'hB: hex_pattern = 7'h03;
      4'hC: hex_pattern = 7'h46;
      4'hD: hex_pattern = 7'h21;
      4'hE: hex_pattern = 7'h06;
      default: hex_pattern = 7'h0E;
    endcase
  endfunction

  // Digit pair 2n+1:2n shows snapshot n; odd digit carries the more significant symbol.
  always_comb begin
    byte_sel = 8'h00;
    seg_next = 7'h7F;
    case (dig[2:1])
      2'd0:    byte_sel = snap0;
      2'd1:    byte_sel = snap1;
      2'd2:    byte_sel = snap2;
      default: byte_sel = 8'h00;
    endcase
`ifdef IO_SCAN_DEC_EN
    if (byte_sel > 8'd99) begin
      seg_next = 7'h3F;
    end else begin
      seg_next = hex_pattern(dig[0] ? 4'(byte_sel / 8'd10) : 4'(byte_sel % 8'd10));
    end
`else
    seg_next = hex_pattern(dig[0] ? byte_sel[7:4] : byte_sel[3:0]);
`endif
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pre        <= 16'd0;
      dig        <= 3'd0;
      snap0      <= 8'h00;
      snap1      <= 8'h00;
      snap2      <= 8'h00;
      frame_tick <= 1'b0;
      an_n       <= 6'h3F;
      seg_n      <= 7'h7F;
    end else begin
      pre <= tick ? 16'd0 : pre + 16'd1;
      if (tick) begin
        // 6 and 7 are unreachable; any such value recovers to digit 0.
        dig <= (dig >= 3'd5) ? 3'd0 : dig + 3'd1;
      end
      if (wrap) begin
        snap0 <= real_out_port0[7:0];
        snap1 <= real_out_port1[7:0];
        snap2 <= real_out_port2[7:0];
      end
      frame_tick <= wrap;
      // Anode and segments load together so digits never ghost.
      an_n  <= ~(6'b000001 << dig);
      seg_n <= seg_next;
    end
  end

endmodule

// File: tb/tb_io_sevenseg_scan.sv
// Bench for io_sevenseg_scan: spec vector tables, hand sequences and a cycle-count reference model.
module tb_io_sevenseg_scan;

  localparam int DIV   = 4;
  localparam int FRAME = 6 * DIV;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] p0 = '0, p1 = '0, p2 = '0;
  logic [5:0]  an_n;
  logic [6:0]  seg_n;
  logic        frame_tick;

  io_sevenseg_scan #(.DIV(DIV)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .real_out_port0 (p0),
    .real_out_port1 (p1),
    .real_out_port2 (p2),
    .an_n           (an_n),
    .seg_n          (seg_n),
    .frame_tick     (frame_tick)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] an;
    logic [6:0] seg;
  } vec_t;

  vec_t       scan_tab[6];
  logic [6:0] pat[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [5:0] an_tab[6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

  int         checks = 0;
  int         passes = 0;
  int         k = 0;
  logic [7:0] m_snap[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, k);
  endtask

  // Symbol shown on display digit d given the model's current snapshot.
  function automatic logic [6:0] model_seg(input int d);
    int b = int'(m_snap[d / 2]);
`ifdef IO_SCAN_DEC_EN
    if (b > 99) return 7'h3F;
    return (d % 2 == 1) ? pat[b / 10] : pat[b % 10];
`else
    return (d % 2 == 1) ? pat[b / 16] : pat[b % 16];
`endif
  endfunction

  // One clock: k counts edges since reset release; the output after edge k
  // shows digit ((k-1)/DIV)%6, and edge k captures the ports when k is a multiple of FRAME.
  task automatic step();
    int         d;
    logic [6:0] e_seg;
    logic       e_ft;
    @(posedge clock);
    k++;
    d     = ((k - 1) / DIV) % 6;
    e_seg = model_seg(d);
    e_ft  = (k % FRAME == 0);
    if (e_ft) begin
      m_snap[0] = p0[7:0];
      m_snap[1] = p1[7:0];
      m_snap[2] = p2[7:0];
    end
    #1;
    check("model_an_n", an_n, an_tab[d]);
    check("model_seg_n", seg_n, e_seg);
    check("model_frame_tick", frame_tick, e_ft);
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (frame_tick !== 1'b1 && n < 3 * FRAME);
    check("frame_timeout", frame_tick, 1'b1);
  endtask

  task automatic restart();
    resetn = 1'b1;
    k = 0;
    for (int i = 0; i < 3; i++) m_snap[i] = 8'h00;
  endtask

  initial begin
    int n;
    logic [6:0] exp_wrap_seg;

`ifdef IO_SCAN_DEC_EN
    // 0x12=18, 0xAB=171, 0x3F=63
    scan_tab = '{'{6'h3E, 7'h00}, '{6'h3D, 7'h79}, '{6'h3B, 7'h3F},
                 '{6'h37, 7'h3F}, '{6'h2F, 7'h30}, '{6'h1F, 7'h02}};
    exp_wrap_seg = 7'h3F;
`else
    scan_tab = '{'{6'h3E, 7'h24}, '{6'h3D, 7'h79}, '{6'h3B, 7'h03},
                 '{6'h37, 7'h08}, '{6'h2F, 7'h0E}, '{6'h1F, 7'h30}};
    exp_wrap_seg = 7'h78;
`endif

    // Reset held for 3 cycles: all dark.
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_an_n", an_n, 6'h3F);
    check("reset_seg_n", seg_n, 7'h7F);
    check("reset_frame_tick", frame_tick, 1'b0);
    restart();
    step();
    check("first_an_n", an_n, 6'h3E);
    check("first_seg_n", seg_n, 7'h40);

    // Hex scan; upper port bits carry noise that must be ignored.
    p0 = 32'hFFFF_FF12;
    p1 = 32'h1234_56AB;
    p2 = 32'h8000_003F;
    wait_frame(n);
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < DIV; j++) begin
        step();
        check("scan_an_n", an_n, scan_tab[i].an);
        check("scan_seg_n", seg_n, scan_tab[i].seg);
      end
    end

    // Tear-free: port0 changes right after the wrap; digits 1:0 keep the old byte.
    p0 = 32'h0000_0055;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < DIV; j++) begin
        step();
        check("tear_seg_n", seg_n, scan_tab[i].seg);
      end
    end
    wait_frame(n);
    check("frame_period", 2 * DIV + n, FRAME);
    step();
    check("tear_new_seg_n", seg_n, 7'h12);

    // Port written in the wrap cycle lands in the immediately following frame.
    while (k % FRAME != FRAME - 1) step();
    p1 = 32'h0000_0077;
    step();
    check("wrap_frame_tick", frame_tick, 1'b1);
    p1 = 32'h0000_0000;
    repeat (2 * DIV + 1) step();
    check("wrap_an_n", an_n, 6'h3B);
    check("wrap_seg_n", seg_n, exp_wrap_seg);

`ifdef IO_SCAN_DEC_EN
    // Decimal: 42 -> ones 2 on digit 0, tens 4 on digit 1; 200 -> dashes.
    p0 = 32'h0000_002A;
    p1 = 32'h0000_00C8;
    wait_frame(n);
    step();
    check("dec_d0_seg_n", seg_n, 7'h24);
    repeat (DIV) step();
    check("dec_d1_seg_n", seg_n, 7'h19);
    repeat (DIV) step();
    check("dec_d2_seg_n", seg_n, 7'h3F);
    repeat (DIV) step();
    check("dec_d3_seg_n", seg_n, 7'h3F);
`endif

    // Randomized port activity against the reference model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0: p0 = $urandom;
          1: p1 = $urandom;
          default: p2 = $urandom;
        endcase
      end
      step();
    end

    // Mid-operation reset while digit 3 is lit.
    p0 = 32'h99; p1 = 32'h42; p2 = 32'hE7;
    n = 0;
    do begin
      step();
      n++;
    end while (((k - 1) / DIV) % 6 != 3 && n < 3 * FRAME);
    check("reach_digit3_an_n", an_n, 6'h37);
    resetn = 1'b0;
    #1;
    check("async_reset_an_n", an_n, 6'h3F);
    check("async_reset_seg_n", seg_n, 7'h7F);
    check("async_reset_frame_tick", frame_tick, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("held_reset_an_n", an_n, 6'h3F);
    restart();
    step();
    check("restart_an_n", an_n, 6'h3E);
    check("restart_seg_n", seg_n, 7'h40);
    repeat (2 * FRAME) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
